// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the external SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        FINISH
    } state_e;

    localparam int unsigned PORT_V = 0;
    localparam int unsigned PORT_G = 1;
    localparam int unsigned NPORTS = 2;
    localparam int unsigned CNT_W  = 4;

endpackage

// File: rtl/sram_arb_select.sv
// Combinational grant selection between the video (V) and game (G) ports.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration; otherwise V
// has fixed priority over G.
module sram_arb_select
    import sram_arb_pkg::*;
(
    input  logic              v_req_i,
    input  logic              g_req_i,
    input  logic              v_mask_i,
    input  logic              g_mask_i,
`ifdef SRAM_ARB_RR_EN
    input  logic              last_g_i,
`endif
    output logic [NPORTS-1:0] gnt_c_o
);

    logic v_ok;
    logic g_ok;

    // A port in its ack cycle is masked so a held request is not reissued.
    assign v_ok = v_req_i & ~v_mask_i;
    assign g_ok = g_req_i & ~g_mask_i;

    // One-hot grant; under contention the priority rule picks a single winner.
    always_comb begin
        gnt_c_o = '0;
`ifdef SRAM_ARB_RR_EN
        if (v_ok && g_ok) begin
            if (last_g_i) begin
                gnt_c_o[PORT_V] = 1'b1;
            end else begin
                gnt_c_o[PORT_G] = 1'b1;
            end
        end else begin
            gnt_c_o[PORT_V] = v_ok;
            gnt_c_o[PORT_G] = g_ok;
        end
`else
        gnt_c_o[PORT_V] = v_ok;
        gnt_c_o[PORT_G] = g_ok & ~v_ok;
`endif
    end

endmodule

// File: rtl/sram_arbiter.sv
// Sequencer for the shared 1M x 16 async SRAM behind a registered tristate
// buffer. Two requesters: V (read-only) and G (read/write with byte enables).
// Build option: SRAM_ARB_RR_EN selects round-robin arbitration instead of
// fixed V-over-G priority.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              v_req,
    input  logic [ADDR_W-1:0] v_addr,
    output logic              v_ack,
    output logic [DATA_W-1:0] v_rdata,
    input  logic              g_req,
    input  logic              g_we,
    input  logic [1:0]        g_be,
    input  logic [ADDR_W-1:0] g_addr,
    input  logic [DATA_W-1:0] g_wdata,
    output logic              g_ack,
    output logic [DATA_W-1:0] g_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic              tri_oe,
    output logic [DATA_W-1:0] tri_wdata,
    input  logic [DATA_W-1:0] tri_rdata
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q;
    logic               owner_g_q;
    logic [NPORTS-1:0]  gnt_c;
`ifdef SRAM_ARB_RR_EN
    logic               last_g_q;
`endif

    // Grant selection; the registered acks double as the re-request masks.
    sram_arb_select u_select (
        .v_req_i  (v_req),
        .g_req_i  (g_req),
        .v_mask_i (v_ack),
        .g_mask_i (g_ack),
`ifdef SRAM_ARB_RR_EN
        .last_g_i (last_g_q),
`endif
        .gnt_c_o  (gnt_c)
    );

    // Access FSM; pin registers are loaded with the values for the state being entered.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            owner_g_q <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_g_q  <= 1'b1;
`endif
            v_ack     <= 1'b0;
            g_ack     <= 1'b0;
            v_rdata   <= '0;
            g_rdata   <= '0;
            busy      <= 1'b0;
            SRAM_ADDR <= '0;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            tri_oe    <= 1'b0;
            tri_wdata <= '0;
        end else begin
            v_ack <= 1'b0;
            g_ack <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_c[PORT_V] || gnt_c[PORT_G]) begin
                        state_q   <= SETUP;
                        busy      <= 1'b1;
                        cnt_q     <= CNT_W'(WAIT_CYCLES - 1);
                        owner_g_q <= gnt_c[PORT_G];
`ifdef SRAM_ARB_RR_EN
                        last_g_q  <= gnt_c[PORT_G];
`endif
                        SRAM_CE_N <= 1'b0;
                        if (gnt_c[PORT_G]) begin
                            SRAM_ADDR <= g_addr;
                            we_q      <= g_we;
                            if (g_we) begin
                                tri_oe    <= 1'b1;
                                tri_wdata <= g_wdata;
                                SRAM_UB_N <= ~g_be[1];
                                SRAM_LB_N <= ~g_be[0];
                            end else begin
                                SRAM_OE_N <= 1'b0;
                                SRAM_UB_N <= 1'b0;
                                SRAM_LB_N <= 1'b0;
                            end
                        end else begin
                            SRAM_ADDR <= v_addr;
                            we_q      <= 1'b0;
                            SRAM_OE_N <= 1'b0;
                            SRAM_UB_N <= 1'b0;
                            SRAM_LB_N <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    // Write data reaches the bus this cycle, so the strobe can open next.
                    state_q <= ACCESS;
                    if (we_q) begin
                        SRAM_WE_N <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q   <= FINISH;
                        SRAM_WE_N <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                FINISH: begin
                    // tri_rdata here is the bus from the last strobed cycle.
                    state_q   <= IDLE;
                    busy      <= 1'b0;
                    SRAM_CE_N <= 1'b1;
                    SRAM_OE_N <= 1'b1;
                    SRAM_WE_N <= 1'b1;
                    SRAM_UB_N <= 1'b1;
                    SRAM_LB_N <= 1'b1;
                    tri_oe    <= 1'b0;
                    if (!we_q) begin
                        if (owner_g_q) begin
                            g_rdata <= tri_rdata;
                        end else begin
                            v_rdata <= tri_rdata;
                        end
                    end
                    g_ack <= owner_g_q;
                    v_ack <= ~owner_g_q;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
